key_judge: RTL
==============

// Module: key_judge
// PURPOSE
//   Chart reader and hit judge for one lane (key K). Walks the lane's note-chart ROM through chart_addr,
//   using the 4-word window note_1..note_4 that the ROM returns for that address.
//   Compares note times against the song frame counter and the lane key level.
//   Emits perfect/good/miss pulses, the combo count and the score to the game logic and HUD.
//   Chart word format: [15:14] type (00 tap, 01 hold head, 10 hold tail, 11 reserved); [13:0] target frame (60 Hz).
// PARAMETERS
//   PERF_WIN  4'd3        |dt| <= PERF_WIN frames -> perfect
//   GOOD_WIN  4'd8        |dt| <= GOOD_WIN frames -> good (must be >= PERF_WIN)
//   PERF_PTS  20'd300     score added per perfect
//   GOOD_PTS  20'd100     score added per good
//   END_WORD  16'h16D3    end-of-chart sentinel word
// PORTS
//   Clk          in   1   system clock
//   Reset_n      in   1   synchronous, active-low reset
//   start        in   1   1-cycle pulse: begin song from chart entry 0
//   run          in   1   1 = playing; 0 = pause (all state frozen)
//   frame        in   14  current song frame, monotonic while run=1
//   key_down     in   1   debounced key K level, 1 = pressed
//   note_1..4    in   16  chart words at chart_addr..chart_addr+3 (combinational ROM)
//   chart_addr   out  8   head-note index into chart ROM
//   hit_perfect  out  1   1-cycle pulse
//   hit_good     out  1   1-cycle pulse
//   miss         out  1   1-cycle pulse
//   hold_active  out  1   1 while a hold note is being held
//   combo        out  10  current combo, saturates at 1023
//   score        out  20  accumulated score, saturates at 20'hFFFFF
//   done         out  1   1 once sentinel reached; held until start/reset
// BEHAVIOUR
//   Reset_n=0 at posedge: all outputs 0, state IDLE; overrides start.
//   States:
//     IDLE: start -> WAIT, clears chart_addr/combo/score.
//     WAIT: judges head note note_1.
//     HOLD: judges tail note note_2.
//     DONE: start -> WAIT (same clears).
//   start in any state restarts as from IDLE.
//   run=0: no transitions, no pulses, key edge detector still tracks key_down. Exception: start is honoured.
//   Key press = rising edge of key_down (registered previous value; reset value 0).
//   Signals: t = note_1[13:0]; dt = |frame - t|; late = frame > t + GOOD_WIN, compared at 15 bits with no wrap.
//   WAIT, priority order:
//     note_1 == END_WORD -> DONE, done=1.
//     type 10/11 at head -> chart_addr += 1, no pulse.
//     late -> miss; addr += 1 (tap) or += 2 (hold: tail is skipped, one miss only).
//     press & dt <= GOOD_WIN -> perfect if dt <= PERF_WIN, else good.
//       Tap: addr += 1.
//       Hold head: -> HOLD, hold_active=1.
//     press outside window -> ignored; no penalty, no addr change.
//   HOLD, with tail time u = note_2[13:0]:
//     key_down=1 & frame >= u -> perfect, addr += 2, -> WAIT.
//     key_down=0 & frame >= u - GOOD_WIN -> good, addr += 2, -> WAIT.
//     key_down=0 earlier -> miss, addr += 2, -> WAIT.
//     hold_active clears with the exit transition.
//   Pulses and score/combo update are registered: visible the cycle after the deciding edge.
//   At most one judgement per cycle.
//   Combo: +1 on perfect/good (saturating); 0 on miss.
//   chart_addr: saturates at 8'd252 (window stays in ROM); reaching 252 also forces DONE.
//   A new head is evaluated the cycle after chart_addr changes.
//   The same press never judges two notes.
// TESTING
//   1 Head 16'h00A8 (t=168); press at frame 170 -> hit_perfect 1 cycle, combo=1, score=300, chart_addr=1.
//   2 Head t=168; press at frame 162 -> hit_good, score=100. No press through frame 176 -> nothing;
//     frame 177 -> miss, combo=0.
//   3 Hold 16'h4946/16'h895A (2374/2394):
//     press at 2374 -> perfect, hold_active=1.
//     Release at 2380 -> miss, combo=0, addr+2.
//     Repeat holding to 2394 -> second perfect, addr+2.
//   4 Press at frame 150 with head t=168 -> no pulse, addr unchanged.
//     Held key with no new edge at 168 -> no hit.
//   5 note_1=16'h16D3 -> done=1, no pulses. start -> done=0, addr=0, combo=0, score=0.
//   6 Reset_n=0 mid-HOLD -> next cycle all outputs 0, IDLE.
//     run=0 during a late note -> no miss until run=1.

Source files
------------

// File: rtl/key_judge_if.sv
// Lane bus between the game logic / chart ROM and the key judge.
// Inputs flow master->slave; judgement results flow back.
interface key_judge_if;
  logic        start;
  logic        run;
  logic [13:0] frame;
  logic        key_down;
  logic [15:0] note_1;
  logic [15:0] note_2;
  logic [15:0] note_3;
  logic [15:0] note_4;
  logic [7:0]  chart_addr;
  logic        hit_perfect;
  logic        hit_good;
  logic        miss;
  logic        hold_active;
  logic [9:0]  combo;
  logic [19:0] score;
  logic        done;

  modport master (
    output start, run, frame, key_down,
    output note_1, note_2, note_3, note_4,
    input  chart_addr, hit_perfect, hit_good,
    input  miss, hold_active, combo, score, done
  );

  modport slave (
    input  start, run, frame, key_down,
    input  note_1, note_2, note_3, note_4,
    output chart_addr, hit_perfect, hit_good,
    output miss, hold_active, combo, score, done
  );
endinterface

// File: rtl/key_judge.sv
// Single-lane chart reader and hit judge: walks the note chart,
// judges key presses/holds and keeps combo and score.
module key_judge #(
  parameter logic [3:0]  PERF_WIN = 4'd3,
  parameter logic [3:0]  GOOD_WIN = 4'd8,
  parameter logic [19:0] PERF_PTS = 20'd300,
  parameter logic [19:0] GOOD_PTS = 20'd100,
  parameter logic [15:0] END_WORD = 16'h16D3
) (
  input logic           Clk,
  input logic           Reset_n,
  key_judge_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_HOLD,
    S_DONE
  } state_t;

  localparam logic [8:0] ADDR_MAX = 9'd252;

  state_t      r_state;
  logic [7:0]  r_addr;
  logic        r_perf;
  logic        r_good;
  logic        r_miss;
  logic        r_hold;
  logic [9:0]  r_combo;
  logic [19:0] r_score;
  logic        r_done;
  logic        r_key_prev;

  logic        w_press;
  logic [14:0] w_f15;
  logic [14:0] w_t15;
  logic [14:0] w_u15;
  logic [14:0] w_gw15;
  logic [13:0] w_dt;
  logic        w_late;
  logic        w_in_win;
  logic        w_is_perf;
  logic        w_tail_ok;
  logic        w_tail_good;
  logic        w_end;

  logic        w_jperf;
  logic        w_jgood;
  logic        w_jmiss;
  logic [1:0]  w_adv;
  state_t      w_nstate;
  logic [8:0]  w_sum;
  logic [7:0]  w_addr_n;
  logic [20:0] w_score_sum;
  logic [19:0] w_pts;
  logic        w_unused;

  assign w_press   = bus.key_down & ~r_key_prev;
  assign w_f15     = {1'b0, bus.frame};
  assign w_t15     = {1'b0, bus.note_1[13:0]};
  assign w_u15     = {1'b0, bus.note_2[13:0]};
  assign w_gw15    = {11'd0, GOOD_WIN};
  assign w_dt      = (w_f15 >= w_t15)
                   ? (bus.frame - bus.note_1[13:0])
                   : (bus.note_1[13:0] - bus.frame);
  assign w_late    = w_f15 > (w_t15 + w_gw15);
  assign w_in_win  = w_dt <= {10'd0, GOOD_WIN};
  assign w_is_perf = w_dt <= {10'd0, PERF_WIN};
  assign w_tail_ok = w_f15 >= w_u15;
  // Released early but within the good window of the tail.
  assign w_tail_good = (w_f15 + w_gw15) >= w_u15;
  assign w_end     = bus.note_1 == END_WORD;
  assign w_unused  = ^{bus.note_3, bus.note_4,
                       bus.note_2[15:14]};

  always_comb begin
    w_jperf  = 1'b0;
    w_jgood  = 1'b0;
    w_jmiss  = 1'b0;
    w_adv    = 2'd0;
    w_nstate = r_state;
    unique case (r_state)
      S_WAIT: begin
        if (w_end) begin
          w_nstate = S_DONE;
        end else if (bus.note_1[15]) begin
          w_adv = 2'd1;
        end else if (w_late) begin
          w_jmiss = 1'b1;
          w_adv   = bus.note_1[14] ? 2'd2 : 2'd1;
        end else if (w_press && w_in_win) begin
          w_jperf = w_is_perf;
          w_jgood = ~w_is_perf;
          if (bus.note_1[14]) w_nstate = S_HOLD;
          else                w_adv    = 2'd1;
        end
      end
      S_HOLD: begin
        if (bus.key_down) begin
          if (w_tail_ok) begin
            w_jperf = 1'b1;
            w_adv   = 2'd2;
          end
        end else if (w_tail_good) begin
          w_jgood = 1'b1;
          w_adv   = 2'd2;
        end else begin
          w_jmiss = 1'b1;
          w_adv   = 2'd2;
        end
        if (w_adv != 2'd0) w_nstate = S_WAIT;
      end
      default: ;
    endcase
    w_sum    = {1'b0, r_addr} + {7'd0, w_adv};
    w_addr_n = w_sum[7:0];
    // Keep the 4-word window inside the ROM; the chart ends here.
    if (w_sum >= ADDR_MAX) begin
      w_addr_n = ADDR_MAX[7:0];
      w_nstate = S_DONE;
    end
  end

  always_comb begin
    w_pts = 20'd0;
    if (w_jperf)      w_pts = PERF_PTS;
    else if (w_jgood) w_pts = GOOD_PTS;
    w_score_sum = {1'b0, r_score} + {1'b0, w_pts};
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_state    <= S_IDLE;
      r_addr     <= 8'd0;
      r_perf     <= 1'b0;
      r_good     <= 1'b0;
      r_miss     <= 1'b0;
      r_hold     <= 1'b0;
      r_combo    <= 10'd0;
      r_score    <= 20'd0;
      r_done     <= 1'b0;
      r_key_prev <= 1'b0;
    end else begin
      r_key_prev <= bus.key_down;
      r_perf     <= 1'b0;
      r_good     <= 1'b0;
      r_miss     <= 1'b0;
      if (bus.start) begin
        r_state <= S_WAIT;
        r_addr  <= 8'd0;
        r_hold  <= 1'b0;
        r_combo <= 10'd0;
        r_score <= 20'd0;
        r_done  <= 1'b0;
      end else if (bus.run) begin
        r_state <= w_nstate;
        r_addr  <= w_addr_n;
        r_perf  <= w_jperf;
        r_good  <= w_jgood;
        r_miss  <= w_jmiss;
        r_hold  <= w_nstate == S_HOLD;
        r_done  <= w_nstate == S_DONE;
        if (w_jmiss)
          r_combo <= 10'd0;
        else if ((w_jperf || w_jgood) && r_combo != 10'h3FF)
          r_combo <= r_combo + 10'd1;
        if (w_score_sum[20])
          r_score <= 20'hFFFFF;
        else
          r_score <= w_score_sum[19:0];
      end
    end
  end

  assign bus.chart_addr  = r_addr;
  assign bus.hit_perfect = r_perf;
  assign bus.hit_good    = r_good;
  assign bus.miss        = r_miss;
  assign bus.hold_active = r_hold;
  assign bus.combo       = r_combo;
  assign bus.score       = r_score;
  assign bus.done        = r_done;

endmodule
